// File: rtl/echo_canceller.sv
// Echo canceller: recovers x[n] = y[n] - (y[n-D] >>> 2) from the echo machine output.
// A circular delay line supplies y[n-D]; FILL masks the delayed term until D samples exist.
`timescale 1ns/1ps
module echo_canceller #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                sample_clock,
   input  logic                reset_n,
   input  logic signed [15:0]  input_sample,
   input  logic                in_valid,
   input  logic [AW-1:0]       delay_len,
   output logic signed [15:0]  output_sample,
   output logic                out_valid,
   output logic                primed
);

   typedef enum logic [1:0] {S_FLUSH, S_FILL, S_RUN} state_t;

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_state_nxt;
   logic [AW-1:0]      r_dly;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_fill;
   logic signed [15:0] r_mem [DEPTH];

   logic [AW-1:0]      w_dly_eff;
   logic [AW-1:0]      w_rd_addr;
   logic               w_dly_chg;
   logic               w_accept;
   logic signed [15:0] w_hist;
   logic signed [15:0] w_x;

   function automatic logic signed [15:0] sar2(input logic signed [15:0] v);
      return v >>> 2;
   endfunction

   // Wrap-around on purpose: the encoder added with wrap, so only wrap inverts it exactly.
   function automatic logic signed [15:0] sub_wrap(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
      return a - b;
   endfunction

   assign w_dly_eff = (r_dly == '0) ? ONE : r_dly;
   assign w_dly_chg = (delay_len != r_dly);
   assign w_accept  = in_valid && (r_state != S_FLUSH) && !w_dly_chg;
   assign w_rd_addr = r_wr_ptr - w_dly_eff;
   assign w_hist    = (r_state == S_RUN) ? sar2(r_mem[w_rd_addr]) : '0;
   assign w_x       = sub_wrap(input_sample, w_hist);
   assign primed    = (r_state == S_RUN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FLUSH: w_state_nxt = S_FILL;
         S_FILL: begin
            if (w_dly_chg)
               w_state_nxt = S_FLUSH;
            else if (w_accept && ((r_fill + ONE) == w_dly_eff))
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_dly_chg)
               w_state_nxt = S_FLUSH;
         end
         default: w_state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge sample_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_FLUSH;
         r_dly         <= '0;
         r_wr_ptr      <= '0;
         r_fill        <= '0;
         output_sample <= '0;
         out_valid     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dly     <= delay_len;
         out_valid <= w_accept;
         if (r_state == S_FLUSH)
            r_fill <= '0;
         else if (w_accept && (r_state == S_FILL))
            r_fill <= r_fill + ONE;
         if (w_accept) begin
            r_wr_ptr      <= r_wr_ptr + ONE;
            output_sample <= w_x;
         end
      end
   end

   // Delay line storage carries no reset; stale words are masked by FILL.
   always_ff @(posedge sample_clock) begin
      if (w_accept)
         r_mem[r_wr_ptr] <= input_sample;
   end

endmodule
